// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - sequential instruction prefetcher with in-order fetch queue
module instr_prefetch #(
    parameter logic [18:0] RESET_PC = 19'h100,
    parameter int          DEPTH    = 4,
    parameter logic [18:0] PC_INC   = 19'h4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_o,
    output logic [18:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [18:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [18:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [18:0] instr_o,
    output logic [18:0] instr_pc_o,
    output logic        halted_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W:0] CRED_LIM = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [18:0] fetch_pc;
    logic [18:0] pc_mem   [DEPTH];
    logic [18:0] data_mem [DEPTH];

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic [PTR_W-1:0] discard_cnt;

    logic [PTR_W-1:0] allocated;
    logic [PTR_W-1:0] in_flight;
    logic [PTR_W-1:0] in_flight_nxt;
    logic             credit_ok;
    logic             gnt_acc;
    logic             rv_acc;
    logic             rv_drop;
    logic             wr;
    logic             pop;

    logic [PTR_W-1:0] read_nxt;
    logic [PTR_W-1:0] fill_nxt;
    logic [IDX_W-1:0] head_idx;
    logic             head_valid_nxt;
    logic [18:0]      head_data_nxt;
    logic [18:0]      head_pc_nxt;

    assign allocated     = alloc_ptr - read_ptr;
    assign in_flight     = (alloc_ptr - fill_ptr) + discard_cnt;
    assign credit_ok     = ({1'b0, allocated} + {1'b0, discard_cnt}) < CRED_LIM;
    assign gnt_acc       = imem_req_o & imem_gnt_i;
    assign rv_acc        = imem_rvalid_i & (in_flight != '0);
    assign rv_drop       = rv_acc & ((discard_cnt != '0) | redirect_i);
    assign wr            = rv_acc & ~rv_drop;
    assign pop           = instr_valid_o & instr_ready_i;
    assign in_flight_nxt = in_flight + PTR_W'(gnt_acc) - PTR_W'(rv_acc);
    assign imem_addr_o   = fetch_pc & 19'h7FFFE;

    always_comb begin
        state_nxt  = state;
        imem_req_o = 1'b0;
        halted_o   = 1'b0;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                imem_req_o = ~halt_i & credit_ok;
                // Only park once every outstanding response, stale or not, has returned.
                if (halt_i && (in_flight_nxt == '0)) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                halted_o = 1'b1;
                if (!halt_i) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next head of queue, with a bypass so a response into an empty queue shows up next cycle.
    always_comb begin
        read_nxt       = read_ptr + PTR_W'(pop);
        fill_nxt       = fill_ptr + PTR_W'(wr);
        head_idx       = read_nxt[IDX_W-1:0];
        head_valid_nxt = (fill_nxt != read_nxt) & ~redirect_i;
        head_pc_nxt    = pc_mem[head_idx];
        head_data_nxt  = data_mem[head_idx];
        if (wr && (fill_ptr == read_nxt)) begin
            head_data_nxt = imem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i & 19'h7FFFE;
        end else if (gnt_acc) begin
            fetch_pc <= fetch_pc + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
            alloc_ptr     <= '0;
            fill_ptr      <= '0;
            read_ptr      <= '0;
            discard_cnt   <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
        end else begin
            if (gnt_acc) begin
                pc_mem[alloc_ptr[IDX_W-1:0]] <= fetch_pc;
            end
            if (wr) begin
                data_mem[fill_ptr[IDX_W-1:0]] <= imem_rdata_i;
            end
            if (redirect_i) begin
                // Everything still outstanding, including this cycle's grant, becomes stale.
                alloc_ptr   <= '0;
                fill_ptr    <= '0;
                read_ptr    <= '0;
                discard_cnt <= in_flight_nxt;
            end else begin
                alloc_ptr <= alloc_ptr + PTR_W'(gnt_acc);
                fill_ptr  <= fill_nxt;
                read_ptr  <= read_nxt;
                if (rv_drop) begin
                    discard_cnt <= discard_cnt - 1'b1;
                end
            end
            instr_valid_o <= head_valid_nxt;
            if (head_valid_nxt) begin
                instr_o    <= head_data_nxt;
                instr_pc_o <= head_pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed and randomized bench for instr_prefetch with a queue-based model
module tb_instr_prefetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        imem_req_o;
    logic [18:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [18:0] imem_rdata_i;
    logic        redirect_i;
    logic [18:0] redirect_pc_i;
    logic        halt_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [18:0] instr_o;
    logic [18:0] instr_pc_o;
    logic        halted_o;

    instr_prefetch #(
        .RESET_PC (19'h100),
        .DEPTH    (DEPTH),
        .PC_INC   (19'h4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .halted_o      (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] addr;
        bit          stale;
    } resp_t;

    int          n_vec = 0;
    int          n_err = 0;
    resp_t       pending[$];
    logic [18:0] exp_q[$];
    logic [18:0] popped[$];
    int          nret;
    int          m_st;
    logic [18:0] m_pc;
    logic [18:0] salt;
    int          n_pops;
    int          n_gnts;
    int          p_gnt, p_rv, p_rdy, p_spur;
    bit          halt_knob;
    bit          redir_req;
    logic [18:0] redir_pc;

    function automatic logic [18:0] mem_word(input logic [18:0] a);
        return (a * 19'd37) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        halt_i        = 1'b0;
        instr_ready_i = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", 32'(imem_addr_o), 32'h100);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_pc", 32'(instr_pc_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pending.delete();
        exp_q.delete();
        nret      = 0;
        m_st      = 0;
        m_pc      = 19'h100;
        halt_knob = 1'b0;
        redir_req = 1'b0;
    endtask

    // One clock: entered and left at a falling edge.
    task automatic cycle();
        bit    ev, exp_req, gnt_acc, rv_acc, pop;
        int    stale_n;
        resp_t r;
        ev = (exp_q.size() > 0) && (nret > 0);
        chk("instr_valid", 32'(instr_valid_o), 32'(ev));
        if (ev) begin
            chk("instr_pc", 32'(instr_pc_o), 32'(exp_q[0]));
            chk("instr", 32'(instr_o), 32'(mem_word(exp_q[0])));
        end
        chk("halted", 32'(halted_o), 32'(m_st == 2));

        imem_gnt_i = ($urandom_range(99) < p_gnt);
        if (pending.size() > 0) begin
            imem_rvalid_i = ($urandom_range(99) < p_rv);
            imem_rdata_i  = mem_word(pending[0].addr);
        end else begin
            imem_rvalid_i = ($urandom_range(99) < p_spur);
            imem_rdata_i  = 19'($urandom);
        end
        instr_ready_i = ($urandom_range(99) < p_rdy);
        redirect_i    = redir_req;
        redirect_pc_i = redir_pc;
        redir_req     = 1'b0;
        halt_i        = halt_knob;
        #1;

        stale_n = 0;
        foreach (pending[i]) if (pending[i].stale) stale_n++;
        exp_req = (m_st == 1) && !halt_i && ((exp_q.size() + stale_n) < DEPTH);
        chk("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) chk("addr", 32'(imem_addr_o), 32'(m_pc));

        gnt_acc = exp_req && imem_gnt_i;
        rv_acc  = imem_rvalid_i && (pending.size() > 0);
        pop     = ev && instr_ready_i;
        if (gnt_acc) n_gnts++;
        if (pop) begin
            popped.push_back(exp_q.pop_front());
            nret--;
            n_pops++;
        end
        if (redirect_i) begin
            if (rv_acc) r = pending.pop_front();
            foreach (pending[i]) pending[i].stale = 1'b1;
            if (gnt_acc) begin
                r.addr  = m_pc;
                r.stale = 1'b1;
                pending.push_back(r);
            end
            exp_q.delete();
            nret = 0;
            m_pc = {redirect_pc_i[18:1], 1'b0};
        end else begin
            if (rv_acc) begin
                r = pending.pop_front();
                if (!r.stale) nret++;
            end
            if (gnt_acc) begin
                exp_q.push_back(m_pc);
                r.addr  = m_pc;
                r.stale = 1'b0;
                pending.push_back(r);
                m_pc = m_pc + 19'h4;
            end
        end
        case (m_st)
            0: m_st = 1;
            1: if (halt_i && (pending.size() == 0)) m_st = 2;
            2: if (!halt_i) m_st = 1;
            default: m_st = 0;
        endcase
        @(negedge clk);
    endtask

    initial begin
        int n1xx;
        salt      = 19'($urandom);
        redir_pc  = '0;
        p_spur    = 0;
        n_pops    = 0;
        n_gnts    = 0;
        @(negedge clk);
        do_reset();

        // Continuous fetch from reset
        p_gnt = 100; p_rv = 100; p_rdy = 100;
        popped.delete(); n_pops = 0;
        repeat (12) cycle();
        chk("t1_pops", 32'(n_pops), 32'd9);
        chk("t1_first_pc", 32'(popped[0]), 32'h100);
        chk("t1_third_pc", 32'(popped[2]), 32'h108);

        // Decode stalled: exactly DEPTH grants, head held
        do_reset();
        p_rdy = 0; n_gnts = 0;
        repeat (12) cycle();
        chk("t2_grants", 32'(n_gnts), 32'd4);
        chk("t2_req_low", 32'(imem_req_o), 32'd0);
        chk("t2_head_pc", 32'(instr_pc_o), 32'h100);
        p_rdy = 100; popped.delete();
        repeat (10) cycle();
        chk("t2_drain0", 32'(popped[0]), 32'h100);
        chk("t2_drain3", 32'(popped[3]), 32'h10C);
        chk("t2_resume", 32'(popped[4]), 32'h110);

        // Redirect with two responses outstanding
        do_reset();
        p_gnt = 100; p_rv = 0; p_rdy = 100;
        repeat (3) cycle();
        p_gnt = 0; redir_req = 1'b1; redir_pc = 19'h2A1;
        cycle();
        p_gnt = 100; p_rv = 100; popped.delete();
        repeat (10) cycle();
        chk("t3_first_pc", 32'(popped[0]), 32'h2A0);
        n1xx = 0;
        foreach (popped[i]) if (popped[i][18:8] == 11'h1) n1xx++;
        chk("t3_no_old", 32'(n1xx), 32'd0);

        // Redirect coinciding with gnt and rvalid
        do_reset();
        p_gnt = 100; p_rv = 100; p_rdy = 100;
        repeat (2) cycle();
        redir_req = 1'b1; redir_pc = 19'h300;
        cycle();
        chk("t4_restart_addr", 32'(imem_addr_o), 32'h300);
        popped.delete();
        repeat (8) cycle();
        chk("t4_first_pc", 32'(popped[0]), 32'h300);

        // Fetch address wraps at the top of the space
        do_reset();
        repeat (2) cycle();
        redir_req = 1'b1; redir_pc = 19'h7FFF8;
        cycle();
        popped.delete();
        repeat (10) cycle();
        chk("t5_pc0", 32'(popped[0]), 32'h7FFF8);
        chk("t5_pc1", 32'(popped[1]), 32'h7FFFC);
        chk("t5_wrap", 32'(popped[2]), 32'h00000);
        chk("t5_after", 32'(popped[3]), 32'h00004);

        // Halt with two in flight, resume, then reset while halted
        do_reset();
        p_gnt = 100; p_rv = 0; p_rdy = 100;
        repeat (3) cycle();
        halt_knob = 1'b1;
        cycle();
        chk("t6_req_drop", 32'(imem_req_o), 32'd0);
        p_rv = 100;
        repeat (2) cycle();
        chk("t6_halted", 32'(halted_o), 32'd1);
        repeat (3) cycle();
        halt_knob = 1'b0; popped.delete();
        repeat (6) cycle();
        chk("t6_resume_pc", 32'(popped[0]), 32'h108);
        halt_knob = 1'b1;
        repeat (6) cycle();
        chk("t6_halted2", 32'(halted_o), 32'd1);
        do_reset();

        // Randomized traffic with redirects, halts and spurious responses
        p_spur = 10;
        for (int blk = 0; blk < 60; blk++) begin
            p_gnt = $urandom_range(100, 20);
            p_rv  = $urandom_range(100, 20);
            p_rdy = $urandom_range(100, 10);
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(99) < 3) begin
                    redir_req = 1'b1;
                    redir_pc  = 19'($urandom);
                end
                if ($urandom_range(99) < 2) halt_knob = ~halt_knob;
                cycle();
            end
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
